// File: rtl/clk_div_int.sv
// clk_div_int: integer clock divider with a clock-mux bypass to CLK for ratios below 2 or when disabled.
// Define CLK_DIV_ODD_EN to divide by odd ratios (near-50 % duty); otherwise DIV_RATIO[0] is ignored.

// Stand-in for the glitch-free clock-mux library cell; the implementation flow swaps in the real cell.
module clk_div_int_mux (
  input  logic clk_a,
  input  logic clk_b,
  input  logic sel_b,
  output logic clk_o
);

  assign clk_o = sel_b ? clk_b : clk_a;

endmodule

module clk_div_int #(
  parameter int unsigned RATIO_WD = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CLK_EN,
  input  logic [RATIO_WD-1:0] DIV_RATIO,
  output logic                DIV_CLK
);

  localparam int unsigned CNT_WD = RATIO_WD - 1;

  logic [RATIO_WD-1:0] ratio_q, ratio_d;
  logic [CNT_WD-1:0]   cnt_q, cnt_d;
  logic                div_q, div_d;

  logic                bypass;
  logic [RATIO_WD-1:0] ratio_in;
  logic [RATIO_WD-1:0] phase_len;
  logic                phase_end;

  assign bypass = !CLK_EN || (ratio_q < RATIO_WD'(2));

`ifdef CLK_DIV_ODD_EN
  logic [RATIO_WD-1:0] hi_len;
  logic [RATIO_WD-1:0] lo_len;

  // The low phase takes the extra cycle of an odd ratio.
  assign ratio_in  = DIV_RATIO;
  assign hi_len    = ratio_q >> 1;
  assign lo_len    = ratio_q - hi_len;
  assign phase_len = div_q ? hi_len : lo_len;
`else
  assign ratio_in  = {DIV_RATIO[RATIO_WD-1:1], 1'b0};
  assign phase_len = ratio_q >> 1;
`endif

  assign phase_end = ({1'b0, cnt_q} == (phase_len - RATIO_WD'(1)));

  // NOTE: defaults are assigned first so every path drives every signal and no latch is inferred.
  always_comb begin
    ratio_d = ratio_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    if (bypass) begin
      ratio_d = ratio_in;
      cnt_d   = '0;
      div_d   = 1'b0;
    end else if (phase_end) begin
      cnt_d = '0;
      div_d = ~div_q;
      // A new ratio is taken only where a full output period ends (falling edge).
      if (div_q) begin
        ratio_d = ratio_in;
      end
    end else begin
      cnt_d = cnt_q + CNT_WD'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ratio_q <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
    end else begin
      ratio_q <= ratio_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
    end
  end

  clk_div_int_mux u_clk_mux (
    .clk_a (div_q),
    .clk_b (CLK),
    .sel_b (bypass),
    .clk_o (DIV_CLK)
  );

endmodule

// File: tb/tb_clk_div_int.sv
// Self-checking bench for clk_div_int: per-cycle expected DIV_CLK shapes are queued as stimulus is
// applied and compared by a monitor that samples DIV_CLK in both halves of every CLK cycle.
module tb_clk_div_int;

  localparam int RATIO_WD = 8;

  // Expected shape of one CLK cycle: {value while CLK high, value while CLK low}.
  localparam logic [1:0] D0 = 2'b00;
  localparam logic [1:0] D1 = 2'b11;
  localparam logic [1:0] BY = 2'b10;

`ifdef CLK_DIV_ODD_EN
  localparam int LO5 = 3, HI5 = 2, LO3 = 2, HI3 = 1;
`else
  localparam int LO5 = 2, HI5 = 2, LO3 = 1, HI3 = 1;
`endif

  logic                clk       = 1'b0;
  logic                rst       = 1'b0;
  logic                clk_en    = 1'b1;
  logic [RATIO_WD-1:0] div_ratio = 8'd4;
  logic                div_clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  clk_div_int #(.RATIO_WD(RATIO_WD)) dut (
    .CLK       (clk),
    .RST       (rst),
    .CLK_EN    (clk_en),
    .DIV_RATIO (div_ratio),
    .DIV_CLK   (div_clk)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change at posedge+1; the expectation pushed then covers the cycle just started.
  task automatic step(input logic [1:0] e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic period(input int lo, input int hi);
    repeat (lo) step(D0);
    repeat (hi) step(D1);
  endtask

  task automatic bypass_for(input int n);
    repeat (n) step(BY);
  endtask

  task automatic check_state_clear(input string tag);
    check({tag, " ratio_q"}, 32'(dut.ratio_q), 32'd0);
    check({tag, " cnt_q"},   32'(dut.cnt_q),   32'd0);
    check({tag, " div_q"},   32'(dut.div_q),   32'd0);
  endtask

  // Monitor: sample at posedge+2 (CLK high) and negedge+2 (CLK low), then compare.
  initial begin
    logic       hi;
    logic       lo;
    logic [1:0] e;
    forever begin
      @(posedge clk);
      #2 hi = div_clk;
      @(negedge clk);
      #2 lo = div_clk;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cyc++;
        check($sformatf("div_clk cycle %0d", cyc), 32'({hi, lo}), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    // Held in reset: DIV_CLK follows CLK and all state is clear.
    bypass_for(3);
    check_state_clear("in_reset");
    rst = 1'b1;
    step(BY);
    // N=4: 2 low, 2 high.
    repeat (3) period(2, 2);

    // Switch to 5 early in a period: the current 4-cycle period completes first.
    div_ratio = 8'd5;
    period(2, 2);
    repeat (3) period(LO5, HI5);

    // Ratio 0 takes effect at the end of the current period, then 1: both bypass.
    div_ratio = 8'd0;
    period(LO5, HI5);
    bypass_for(4);
    div_ratio = 8'd1;
    bypass_for(4);

    // Disabled with ratio 8: bypass, switched combinationally.
    clk_en    = 1'b0;
    div_ratio = 8'd8;
    bypass_for(4);
    div_ratio = 8'd6;
    bypass_for(1);

    // Enable at N=6, then change to 10 halfway through a high phase.
    clk_en = 1'b1;
    period(3, 3);
    repeat (3) step(D0);
    step(D1);
    div_ratio = 8'd10;
    repeat (2) step(D1);
    repeat (2) period(5, 5);

    // N=8, drop CLK_EN in the high phase; re-enable starts with a full low phase.
    div_ratio = 8'd8;
    period(5, 5);
    repeat (4) step(D0);
    repeat (2) step(D1);
    clk_en = 1'b0;
    bypass_for(3);
    check("bypass cnt_q", 32'(dut.cnt_q), 32'd0);
    check("bypass div_q", 32'(dut.div_q), 32'd0);
    clk_en = 1'b1;
    repeat (2) period(4, 4);

    // N=3, reset asserted during the low phase: DIV_CLK returns to CLK at once.
    div_ratio = 8'd3;
    period(4, 4);
    period(LO3, HI3);
    step(D0);
    rst = 1'b0;
    step(BY);
    bypass_for(2);
    check_state_clear("mid_reset");
    rst = 1'b1;
    step(BY);
    repeat (2) period(LO3, HI3);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_int.md
# clk_div_int

Integer clock divider that generates a slower clock from `CLK` for downstream logic, such as the UART TX/RX clock domains. It sits directly downstream of the reset synchronizer: its `RST` input is that synchronizer's `SYNC_RST` output for the `CLK` domain. Even ratios give a 50 % duty cycle, odd ratios give a near-50 % duty cycle, and a ratio below 2 (or a disabled block) passes `CLK` straight through.

## Interface
- `RATIO_WD`, default 8: width of the division-ratio input.
- `CLK`, in, 1: reference clock. All registers are clocked on its rising edge.
- `RST`, in, 1: asynchronous active-low reset, driven by the synchronized reset of the `CLK` domain.
- `CLK_EN`, in, 1: divider enable. 0 selects bypass.
- `DIV_RATIO`, in, `RATIO_WD`: division ratio N. Values 0 and 1 select bypass.
- `DIV_CLK`, out, 1: divided clock, or `CLK` when in bypass.

## Operation
- Internal state:
  - `ratio_q[RATIO_WD-1:0]`: latched ratio. Reset value 0.
  - `cnt[RATIO_WD-2:0]`: phase counter. Reset value 0.
  - `div_q`: divided-clock register. Reset value 0.
- Bypass condition: `bypass = !CLK_EN || (ratio_q < 2)`.
  - `DIV_CLK = bypass ? CLK : div_q`, implemented as a single glitch-free clock-mux cell.
  - In reset, `ratio_q` is 0, so `DIV_CLK` follows `CLK`.
- Ratio load: `ratio_q` loads `DIV_RATIO` on any rising edge where either:
  - the block is in bypass, or
  - `div_q` toggles from 1 to 0 (end of a full output period).
  - At no other time does a `DIV_RATIO` change affect the current period.
- Phase lengths for N = `ratio_q` ≥ 2:
  - Even N: low phase N/2 cycles, high phase N/2 cycles.
  - Odd N: low phase (N+1)/2 cycles, high phase (N-1)/2 cycles.
- Counter and toggle:
  - `cnt` increments each rising edge.
  - When `cnt == phase_len-1`, `div_q` toggles and `cnt` clears to 0.
  - `phase_len` is selected by the current `div_q` value (low or high phase).
- While in bypass: `cnt` is held at 0 and `div_q` at 0 on every edge. Every output period therefore starts with its low phase.
- `CLK_EN` falling mid-period: the output switches to bypass combinationally, and counter state clears on the next edge. No partial period is completed.
- Reset asserted mid-operation: all state clears asynchronously and `DIV_CLK` returns to `CLK` immediately.
- Maximum ratio: 2^`RATIO_WD`-1. `cnt` is wide enough for the largest phase, ceil(N/2).

## Timing
- Leaving bypass: let E0 be the first rising edge at which `ratio_q` latches N ≥ 2 with `CLK_EN=1`.
  - `DIV_CLK` is 0 from E0.
  - First rise at E0 + low-phase cycles; first fall at E0 + N cycles.
- Steady state: output period is exactly N `CLK` cycles, and edges of `DIV_CLK` align to rising edges of `CLK`.
- Ratio change from N1 to N2 while dividing: the current N1 period completes. N2 applies from the falling edge that ends it.
- Ratio change to a value below 2 while dividing: bypass begins at the end of the current period.
- `DIV_CLK` is declared as a generated clock for STA, covering both mux inputs.

## Configuration
- `CLK_DIV_ODD_EN` defined: odd ratios are supported as described above.
- `CLK_DIV_ODD_EN` undefined:
  - `DIV_RATIO[0]` is ignored on load, so an odd N behaves as N-1.
  - N=1 behaves as 0, i.e. bypass.
  - High and low phases are always equal, and the odd-phase select logic is removed.

## Test plan
- Reset then release with `CLK_EN=1`, `DIV_RATIO=4`: during reset `DIV_CLK` equals `CLK`. After E0 the output is low 2 cycles and high 2 cycles, repeating.
- `DIV_RATIO=5` with the macro defined: low 3 cycles, high 2 cycles, period 5. With the macro undefined: low 2, high 2, period 4.
- `DIV_RATIO=0`, then 1, with `CLK_EN=1`: `DIV_CLK` is cycle-identical to `CLK`. Then set `CLK_EN=0` with `DIV_RATIO=8`: still `CLK`.
- Change `DIV_RATIO` from 6 to 10 at the midpoint of a high phase: the current period stays 6 cycles. The next period is low 5 and high 5.
- Drop `CLK_EN` mid-high-phase at N=8: `DIV_CLK` follows `CLK` immediately. On re-enable, a full low phase of 4 cycles precedes the first rise.
- Assert `RST` mid-period at N=3: `DIV_CLK` returns to `CLK` asynchronously and the internal state reads 0. After release, the first period is low 2, high 1.
